// File: rtl/rec_buf_pkg.sv
// Shared types and constants for the CAN receive-buffer sequencer.
package rec_buf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ID,
        ST_RD_W1,
        ST_RD_W2,
        ST_RD_W3,
        ST_RD_W4,
        ST_FLUSH,
        ST_HOLD
    } state_e;

    localparam logic [4:0] ADDR_ID = 5'b00101;
    localparam logic [4:0] ADDR_W1 = 5'b00011;
    localparam logic [4:0] ADDR_W2 = 5'b00010;
    localparam logic [4:0] ADDR_W3 = 5'b00001;
    localparam logic [4:0] ADDR_W4 = 5'b00000;

    localparam int SEQ_LEN = 5;

    // Register address driven to the CAN controller while in a read state.
    function automatic logic [4:0] read_addr(input state_e s);
        case (s)
            ST_RD_ID: read_addr = ADDR_ID;
            ST_RD_W1: read_addr = ADDR_W1;
            ST_RD_W2: read_addr = ADDR_W2;
            ST_RD_W3: read_addr = ADDR_W3;
            ST_RD_W4: read_addr = ADDR_W4;
            default:  read_addr = 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/rec_seq_timer.sv
// HOLD-state ack timeout counter: cleared by load_i, counts while en_i, saturates at LIMIT.
module rec_seq_timer #(
    parameter int LIMIT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [15:0] LimitVal = 16'(LIMIT);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = 16'd0;
        else if (en_i && (cnt_q != LimitVal))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= 16'd0;
        else
            cnt_q <= cnt_d;
    end

    assign expire_o = (cnt_q == LimitVal);

endmodule

// File: rtl/rec_buf_seq.sv
// Receive-side sequencer: reads the five CAN receive registers into the message buffer,
// then holds msg_valid until acked. Optional HOLD timeout under `REC_SEQ_TIMEOUT_EN.
module rec_buf_seq
    import rec_buf_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done,
    output logic       can_rd,
    output logic [4:0] can_addr,
    output logic       buf_en,
    output logic [4:0] buf_addr,
    output logic       msg_valid,
    input  logic       msg_ack,
    output logic       busy,
    output logic       overrun,
    input  logic       ovr_clr,
    output logic       timeout
);

    state_e     state_q;
    logic       pending_q, pending_d;
    logic       overrun_q, overrun_d;
    logic       buf_en_q;
    logic [4:0] buf_addr_q;
    logic       start_seq;
    logic       expire;

    // Leaving IDLE consumes the pending message; a fresh rx_done alongside it stays queued.
    assign start_seq = (state_q == ST_IDLE) && (pending_q || rx_done);
    assign pending_d = start_seq ? (pending_q && rx_done) : (pending_q || rx_done);
    assign overrun_d = (rx_done && pending_q && !start_seq) ? 1'b1 :
                       (ovr_clr ? 1'b0 : overrun_q);

`ifdef REC_SEQ_TIMEOUT_EN
    logic timer_expire;

    rec_seq_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (state_q == ST_FLUSH),
        .en_i    (state_q == ST_HOLD),
        .expire_o(timer_expire)
    );

    assign expire = (state_q == ST_HOLD) && timer_expire && !msg_ack;
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            buf_en_q   <= 1'b0;
            buf_addr_q <= 5'b00000;
        end else begin
            case (state_q)
                ST_IDLE:  if (start_seq) state_q <= ST_RD_ID;
                ST_RD_ID: state_q <= ST_RD_W1;
                ST_RD_W1: state_q <= ST_RD_W2;
                ST_RD_W2: state_q <= ST_RD_W3;
                ST_RD_W3: state_q <= ST_RD_W4;
                ST_RD_W4: state_q <= ST_FLUSH;
                ST_FLUSH: state_q <= ST_HOLD;
                ST_HOLD:  if (msg_ack || expire) state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            // Buffer write trails the register read by the one-cycle read latency.
            buf_en_q   <= can_rd;
            buf_addr_q <= can_addr;
        end
    end

    assign can_rd    = (state_q inside {ST_RD_ID, ST_RD_W1, ST_RD_W2, ST_RD_W3, ST_RD_W4});
    assign can_addr  = read_addr(state_q);
    assign buf_en    = buf_en_q;
    assign buf_addr  = buf_addr_q;
    assign msg_valid = (state_q == ST_HOLD);
    assign busy      = (state_q != ST_IDLE);
    assign overrun   = overrun_q;
    assign timeout   = expire;

endmodule

// File: tb/tb_rec_buf_seq.sv
// Self-checking bench for rec_buf_seq; read/write address streams are checked via scoreboard queues.
module tb_rec_buf_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_done = 1'b0;
    logic       msg_ack = 1'b0;
    logic       ovr_clr = 1'b0;
    logic       can_rd, buf_en, msg_valid, busy, overrun, timeout;
    logic [4:0] can_addr, buf_addr;

    int checks = 0;
    int errors = 0;

    logic [4:0] rdQ[$];
    logic [4:0] wrQ[$];

    always #5 clk = ~clk;

    rec_buf_seq #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_done  (rx_done),
        .can_rd   (can_rd),
        .can_addr (can_addr),
        .buf_en   (buf_en),
        .buf_addr (buf_addr),
        .msg_valid(msg_valid),
        .msg_ack  (msg_ack),
        .busy     (busy),
        .overrun  (overrun),
        .ovr_clr  (ovr_clr),
        .timeout  (timeout)
    );

    function automatic bit win(input int c, input int s, input int lo, input int hi);
        return (c >= s + lo) && (c <= s + hi);
    endfunction

    // Expected {can_rd, buf_en, msg_valid, busy} for a sequence accepted at cycle s, last HOLD cycle e.
    function automatic logic [3:0] seqCtl(input int c, input int s, input int e);
        return {win(c, s, 1, 5), win(c, s, 2, 6), (c >= s + 7) && (c <= e), (c >= s + 1) && (c <= e)};
    endfunction

    function automatic logic [5:0] ctl();
        return {can_rd, buf_en, msg_valid, busy, overrun, timeout};
    endfunction

    task automatic pushSeq();
        logic [4:0] seqAddr[5];
        seqAddr = '{5'd5, 5'd3, 5'd2, 5'd1, 5'd0};
        foreach (seqAddr[i]) begin
            rdQ.push_back(seqAddr[i]);
            wrQ.push_back(seqAddr[i]);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({ctl(), can_addr, buf_addr} !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_state got %b want all zero", {ctl(), can_addr, buf_addr});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sequence();
        logic [5:0] exp;
        logic [4:0] a;
        for (int cyc = 0; cyc <= 9; cyc++) begin
            rx_done = (cyc == 0);
            msg_ack = (cyc == 3) || (cyc == 7);
            if (cyc == 0) pushSeq();
            @(negedge clk);
            exp = {seqCtl(cyc, 0, 7), 2'b00};
            checks++;
            if (ctl() !== exp) begin
                errors++;
                $display("[TB] FAIL seq_ctl cyc %0d got %b want %b", cyc, ctl(), exp);
            end
            if (can_rd) begin
                checks++;
                a = (rdQ.size() != 0) ? rdQ.pop_front() : 5'bxxxxx;
                if (can_addr !== a) begin
                    errors++;
                    $display("[TB] FAIL seq_rd_addr cyc %0d got %0d want %0d", cyc, can_addr, a);
                end
            end
            if (buf_en) begin
                checks++;
                a = (wrQ.size() != 0) ? wrQ.pop_front() : 5'bxxxxx;
                if (buf_addr !== a) begin
                    errors++;
                    $display("[TB] FAIL seq_buf_addr cyc %0d got %0d want %0d", cyc, buf_addr, a);
                end
            end
            @(posedge clk); #1;
        end
        rx_done = 1'b0;
        msg_ack = 1'b0;
        checks++;
        if (rdQ.size() + wrQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL seq_drain got %0d left want 0", rdQ.size() + wrQ.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp;
        logic [4:0] a;
        for (int cyc = 0; cyc <= 17; cyc++) begin
            rx_done = (cyc == 0) || (cyc == 3);
            msg_ack = (cyc == 7) || (cyc == 15);
            if (rx_done) pushSeq();
            @(negedge clk);
            exp = {seqCtl(cyc, 0, 7) | seqCtl(cyc, 8, 15), 2'b00};
            checks++;
            if (ctl() !== exp) begin
                errors++;
                $display("[TB] FAIL b2b_ctl cyc %0d got %b want %b", cyc, ctl(), exp);
            end
            if (can_rd) begin
                checks++;
                a = (rdQ.size() != 0) ? rdQ.pop_front() : 5'bxxxxx;
                if (can_addr !== a) begin
                    errors++;
                    $display("[TB] FAIL b2b_rd_addr cyc %0d got %0d want %0d", cyc, can_addr, a);
                end
            end
            if (buf_en) begin
                checks++;
                a = (wrQ.size() != 0) ? wrQ.pop_front() : 5'bxxxxx;
                if (buf_addr !== a) begin
                    errors++;
                    $display("[TB] FAIL b2b_buf_addr cyc %0d got %0d want %0d", cyc, buf_addr, a);
                end
            end
            @(posedge clk); #1;
        end
        rx_done = 1'b0;
        msg_ack = 1'b0;
        checks++;
        if (rdQ.size() + wrQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_drain got %0d left want 0", rdQ.size() + wrQ.size());
        end
    endtask

    task automatic test_overrun();
        logic [5:0] exp;
        logic [4:0] a;
        logic       expOvr;
        for (int cyc = 0; cyc <= 25; cyc++) begin
            rx_done = (cyc == 0) || (cyc == 3) || (cyc == 5) || (cyc == 12) || (cyc == 13);
            msg_ack = (cyc == 7) || (cyc == 15) || (cyc == 23);
            ovr_clr = (cyc == 10) || (cyc == 13) || (cyc == 24);
            // Only rx_done with nothing already queued yields a distinct read sequence.
            if ((cyc == 0) || (cyc == 3) || (cyc == 12)) pushSeq();
            @(negedge clk);
            expOvr = win(cyc, 6, 0, 4) || win(cyc, 14, 0, 10);
            exp = {seqCtl(cyc, 0, 7) | seqCtl(cyc, 8, 15) | seqCtl(cyc, 16, 23), expOvr, 1'b0};
            checks++;
            if (ctl() !== exp) begin
                errors++;
                $display("[TB] FAIL ovr_ctl cyc %0d got %b want %b", cyc, ctl(), exp);
            end
            if (can_rd) begin
                checks++;
                a = (rdQ.size() != 0) ? rdQ.pop_front() : 5'bxxxxx;
                if (can_addr !== a) begin
                    errors++;
                    $display("[TB] FAIL ovr_rd_addr cyc %0d got %0d want %0d", cyc, can_addr, a);
                end
            end
            if (buf_en) begin
                checks++;
                a = (wrQ.size() != 0) ? wrQ.pop_front() : 5'bxxxxx;
                if (buf_addr !== a) begin
                    errors++;
                    $display("[TB] FAIL ovr_buf_addr cyc %0d got %0d want %0d", cyc, buf_addr, a);
                end
            end
            @(posedge clk); #1;
        end
        rx_done = 1'b0;
        msg_ack = 1'b0;
        ovr_clr = 1'b0;
        checks++;
        if (rdQ.size() + wrQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL ovr_drain got %0d left want 0", rdQ.size() + wrQ.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] exp;
        logic [4:0] a;
        for (int cyc = 0; cyc <= 2; cyc++) begin
            rx_done = (cyc == 0);
            if (cyc == 0) pushSeq();
            @(negedge clk);
            exp = {seqCtl(cyc, 0, 7), 2'b00};
            checks++;
            if (ctl() !== exp) begin
                errors++;
                $display("[TB] FAIL rstmid_ctl cyc %0d got %b want %b", cyc, ctl(), exp);
            end
            if (can_rd) begin
                checks++;
                a = (rdQ.size() != 0) ? rdQ.pop_front() : 5'bxxxxx;
                if (can_addr !== a) begin
                    errors++;
                    $display("[TB] FAIL rstmid_rd_addr cyc %0d got %0d want %0d", cyc, can_addr, a);
                end
            end
            if (buf_en) begin
                checks++;
                a = (wrQ.size() != 0) ? wrQ.pop_front() : 5'bxxxxx;
                if (buf_addr !== a) begin
                    errors++;
                    $display("[TB] FAIL rstmid_buf_addr cyc %0d got %0d want %0d", cyc, buf_addr, a);
                end
            end
            @(posedge clk); #1;
        end
        rx_done = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({ctl(), can_addr, buf_addr} !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL rstmid_async got %b want all zero", {ctl(), can_addr, buf_addr});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        rdQ.delete();
        wrQ.delete();
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            checks++;
            if (ctl() !== 6'b000000) begin
                errors++;
                $display("[TB] FAIL rstmid_idle cyc %0d got %b want 000000", cyc, ctl());
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
`ifdef REC_SEQ_TIMEOUT_EN
        logic [5:0] exp;
        for (int run = 0; run < 2; run++) begin
            for (int cyc = 0; cyc <= 13; cyc++) begin
                rx_done = (cyc == 0);
                msg_ack = (run == 1) && (cyc == 11);
                @(negedge clk);
                exp = {seqCtl(cyc, 0, 11), 1'b0, (run == 0) && (cyc == 11)};
                checks++;
                if (ctl() !== exp) begin
                    errors++;
                    $display("[TB] FAIL timeout_run%0d cyc %0d got %b want %b", run, cyc, ctl(), exp);
                end
                @(posedge clk); #1;
            end
        end
`else
        logic [5:0] exp;
        for (int cyc = 0; cyc <= 21; cyc++) begin
            rx_done = (cyc == 0);
            msg_ack = (cyc == 20);
            @(negedge clk);
            exp = {seqCtl(cyc, 0, 20), 2'b00};
            checks++;
            if (ctl() !== exp) begin
                errors++;
                $display("[TB] FAIL hold_wait cyc %0d got %b want %b", cyc, ctl(), exp);
            end
            @(posedge clk); #1;
        end
`endif
        rx_done = 1'b0;
        msg_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rec_buf_seq.md
# rec_buf_seq

Receive-side sequencer for the CAN bridge. On each receive-complete event from the CAN controller it reads the five receive registers in a fixed order (ID, then data words 1–4) and drives the enable and address of the receive message buffer, aligned to the register read latency. It then presents a `msg_valid`/`msg_ack` handshake to the bridge controller and tracks lost messages. It sits between the CAN controller register port, the receive message buffer, and the bridge FSM.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1023: ack wait limit in HOLD, in clk cycles. Range 1..65535. Used only with `REC_SEQ_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `rx_done` in 1: single-cycle pulse from the CAN controller; a new message is in the receive registers.
- `can_rd` out 1: register read strobe to the CAN controller.
- `can_addr` out 5: register address for the read. Data returns on the cycle after `can_rd`.
- `buf_en` out 1: write enable to the receive message buffer.
- `buf_addr` out 5: buffer select; equals `can_addr` delayed by one cycle.
- `msg_valid` out 1: complete message held in the buffer.
- `msg_ack` in 1: bridge has consumed the message.
- `busy` out 1: high in any state other than IDLE.
- `overrun` out 1: sticky lost-message flag.
- `ovr_clr` in 1: clears `overrun`.
- `timeout` out 1: one-cycle pulse when the ack wait expires. Tied 0 without the macro.

## Operation
- FSM states: IDLE, RD_ID, RD_W1, RD_W2, RD_W3, RD_W4, FLUSH, HOLD.
- `pending` flag:
  - Set by `rx_done`.
  - Cleared on the IDLE→RD_ID transition.
  - If `rx_done` coincides with that clear, `pending` stays set.
- IDLE→RD_ID when `pending` = 1 (or `rx_done` = 1 in that same cycle).
- Read states drive `can_rd` = 1 with these `can_addr` values:
  - RD_ID: 5'b00101
  - RD_W1: 5'b00011
  - RD_W2: 5'b00010
  - RD_W3: 5'b00001
  - RD_W4: 5'b00000
- Each read state advances unconditionally.
- Pipeline register: `buf_en` <= `can_rd` and `buf_addr` <= `can_addr`, every cycle.
- FLUSH: no read. The last `buf_en` (address 0) is asserted in this cycle. Next state is HOLD.
- HOLD: `msg_valid` = 1.
  - On `msg_ack` = 1, go to IDLE; `msg_valid` deasserts the next cycle.
  - If `pending` is already set on entry to IDLE, the next sequence starts immediately.
- `msg_ack` outside HOLD is ignored.
- Overrun: `overrun` is set if `rx_done` arrives while `pending` = 1 and `pending` is not being cleared that cycle.
  - This happens when a message is still queued during a read sequence or HOLD.
  - The queued message is not re-read twice. The registers hold only the latest message.
- `ovr_clr` and a set event in the same cycle: set wins.
- Outputs are registered (Moore); `can_rd`/`can_addr` decode from the state register.

## Timing
- Reset values: `can_rd`=0, `can_addr`=5'b00000, `buf_en`=0, `buf_addr`=5'b00000, `msg_valid`=0, `busy`=0, `overrun`=0, `timeout`=0. `pending`=0, state IDLE, timer 0.
- With `rx_done` at cycle 0 in IDLE:
  - RD_ID at cycle 1.
  - `can_rd` high in cycles 1–5.
  - `buf_en` high in cycles 2–6.
  - `msg_valid` rises at cycle 7.
- Minimum period between consecutive messages: 8 cycles (ack in cycle 7).
- Reset mid-sequence returns everything to reset values immediately. A partially written buffer is not flagged valid.

## Configuration
- `REC_SEQ_TIMEOUT_EN` defined:
  - A 16-bit counter clears on HOLD entry and counts in HOLD.
  - When it reaches `TIMEOUT_CYCLES` without `msg_ack`: pulse `timeout`, drop `msg_valid`, go to IDLE.
  - `msg_ack` in the expiry cycle takes priority; no timeout.
- Not defined: no counter; HOLD waits indefinitely; `timeout` tied 0.

## Structure
- Package `rec_buf_pkg`:
  - State enum.
  - Register address constants `ADDR_ID`=5'b00101, `ADDR_W1`=5'b00011, `ADDR_W2`=5'b00010, `ADDR_W3`=5'b00001, `ADDR_W4`=5'b00000.
  - Sequence length constant (5).
- Sub-module `rec_seq_timer`: the HOLD timeout counter (load/enable/expire). Instantiated only under `REC_SEQ_TIMEOUT_EN`.

## Test plan
- Reset, then `rx_done` at cycle 0 → `can_addr` 5,3,2,1,0 in cycles 1–5; `buf_en` with `buf_addr` 5,3,2,1,0 in cycles 2–6; `msg_valid`=1 at cycle 7.
- `msg_ack` at cycle 7, second `rx_done` at cycle 3 → `overrun` stays 0; second sequence starts at cycle 8.
- `rx_done` at cycles 0, 3, 5 → `overrun`=1 at cycle 6; `ovr_clr` for one cycle → 0.
- `rst` low at cycle 3 → all outputs 0 next cycle; no `msg_valid` after release without a new `rx_done`.
- With the macro and `TIMEOUT_CYCLES`=4, no ack → `timeout` pulse at cycle 11, `msg_valid`=0 at cycle 12; ack at cycle 11 → no pulse.
